mul_pp_seq: RTL and testbench

MUL_PP_SEQ -- requirements
Module: mul_pp_seq

---
 rtl/mul_pkg.sv | 13 +
 rtl/mul_pp_unit.sv | 19 +
 rtl/mul_pp_seq.sv | 104 ++++++++++
 tb/tb_mul_pp_seq.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared types and defaults for the sequential digit-serial multiplier.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DIGIT = 8;

endpackage

// File: rtl/mul_pp_unit.sv
// Combinational DIGITxDIGIT unsigned multiplier producing one partial product.
module mul_pp_unit
    import mul_pkg::*;
#(
    parameter int DIGIT = DEFAULT_DIGIT
) (
    input  logic [DIGIT-1:0]   i_a,
    input  logic [DIGIT-1:0]   i_b,
    output logic [2*DIGIT-1:0] o_p
);

    logic [2*DIGIT-1:0] w_a_ext;
    logic [2*DIGIT-1:0] w_b_ext;

    assign w_a_ext = {{DIGIT{1'b0}}, i_a};
    assign w_b_ext = {{DIGIT{1'b0}}, i_b};
    assign o_p     = w_a_ext * w_b_ext;

endmodule

// File: rtl/mul_pp_seq.sv
// Sequential unsigned multiplier: one DIGITxDIGIT partial product per cycle,
// N*N cycles per operation, valid/ready handshakes on both sides.
module mul_pp_seq
    import mul_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DIGIT = DEFAULT_DIGIT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [2*WIDTH-1:0] y,
    output logic               out_valid,
    input  logic               out_ready
);

    localparam int N  = (DIGIT > 0) ? WIDTH / DIGIT : 1;
    localparam int NN = N * N;
    localparam int KW = (NN > 1) ? $clog2(NN) : 1;
    localparam int PW = 2 * WIDTH;

    if ((WIDTH < 1) || (DIGIT < 1) || ((DIGIT > 0) && (WIDTH % DIGIT != 0))) begin : g_bad_params
        $error("mul_pp_seq: WIDTH must be >= 1 and a multiple of DIGIT >= 1");
    end

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [PW-1:0]      r_acc;
    logic [KW-1:0]      r_k;

    logic [KW-1:0]      w_i;
    logic [KW-1:0]      w_j;
    logic [DIGIT-1:0]   w_a_dig;
    logic [DIGIT-1:0]   w_b_dig;
    logic [2*DIGIT-1:0] w_pp;
    logic [PW-1:0]      w_pp_sh;
    logic               w_accept;
    logic               w_last;

    // Step k walks a's digits fastest: i selects the digit of b, j the digit of a.
    assign w_i     = KW'(int'(r_k) / N);
    assign w_j     = KW'(int'(r_k) % N);
    assign w_a_dig = DIGIT'(r_a >> (DIGIT * int'(w_j)));
    assign w_b_dig = DIGIT'(r_b >> (DIGIT * int'(w_i)));
    assign w_pp_sh = PW'(w_pp) << (DIGIT * (int'(w_i) + int'(w_j)));
    assign w_last  = (r_k == KW'(NN - 1));

    mul_pp_unit #(
        .DIGIT (DIGIT)
    ) u_pp_unit (
        .i_a (w_a_dig),
        .i_b (w_b_dig),
        .o_p (w_pp)
    );

    assign in_ready  = (r_state == IDLE) || ((r_state == DONE) && out_ready);
    assign w_accept  = in_valid && in_ready;
    assign out_valid = (r_state == DONE);
    assign y         = r_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_k     <= '0;
        end else if (w_accept) begin
            // Covers both IDLE and the DONE hand-off that starts the next operation.
            r_state <= MUL;
            r_a     <= a;
            r_b     <= b;
            r_acc   <= '0;
            r_k     <= '0;
        end else begin
            case (r_state)
                MUL: begin
                    r_acc <= r_acc + w_pp_sh;
                    if (w_last) begin
                        r_state <= DONE;
                    end else begin
                        r_k <= r_k + KW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                IDLE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_pp_seq.sv
// Self-checking bench for mul_pp_seq: default 32/8 instance plus a 16/16 (N=1) instance.
module tb_mul_pp_seq;

    localparam int LAT = (32 / 8) * (32 / 8);

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] y;
    logic        out_valid;
    logic        out_ready;

    logic [15:0] a1;
    logic [15:0] b1;
    logic        in_valid1;
    logic        in_ready1;
    logic [31:0] y1;
    logic        out_valid1;
    logic        out_ready1;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mul_pp_seq dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    mul_pp_seq #(
        .WIDTH (16),
        .DIGIT (16)
    ) dut1 (
        .clk       (clk),
        .rst       (rst),
        .a         (a1),
        .b         (b1),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .y         (y1),
        .out_valid (out_valid1),
        .out_ready (out_ready1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input string tag, input logic [31:0] ta, input logic [31:0] tb2);
        int w;
        w = 0;
        while (!in_ready && w < 50) begin
            tick();
            w++;
        end
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        a        = ta;
        b        = tb2;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            tick();
            cyc++;
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb2);
        logic [63:0] exp_y;
        int          cyc;
        exp_y = {32'd0, ta} * {32'd0, tb2};
        start(tag, ta, tb2);
        wait_done(cyc);
        chk({tag, "_lat"}, 64'(cyc), 64'(LAT));
        chk({tag, "_y"}, y, exp_y);
    endtask

    task automatic drain(input string tag, input int hold);
        logic [63:0] saved;
        logic        bad;
        saved = y;
        bad   = 1'b0;
        repeat (hold) begin
            tick();
            if (!out_valid || y !== saved || in_ready) bad = 1'b1;
        end
        if (hold > 0) chk({tag, "_hold_stable"}, 64'(bad), 64'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_drained"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [15:0] sa;
        logic [15:0] sb;
        logic        bad;
        int          cyc;

        rst        = 1'b1;
        a          = '0;
        b          = '0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        a1         = '0;
        b1         = '0;
        in_valid1  = 1'b0;
        out_ready1 = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_y", y, 64'd0);
        chk("rst_out_valid_n1", 64'(out_valid1), 64'd0);
        chk("rst_in_ready_n1", 64'(in_ready1), 64'd1);

        run_op("m3x5", 32'd3, 32'd5);
        chk("m3x5_const", y, 64'h0000_0000_0000_000F);
        drain("m3x5", 0);

        run_op("mfull", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("mfull_const", y, 64'hFFFF_FFFE_0000_0001);
        drain("mfull", 0);

        run_op("bp", 32'h0001_0000, 32'h0001_0000);
        chk("bp_const", y, 64'h0000_0001_0000_0000);
        drain("bp", 10);

        // Back-to-back: consume a result and accept 7*6 on the same edge.
        run_op("prev", $urandom, $urandom);
        a         = 32'd7;
        b         = 32'd6;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("b2b_in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("b2b_consumed", 64'(out_valid), 64'd0);
        wait_done(cyc);
        chk("b2b_lat", 64'(cyc), 64'(LAT));
        chk("b2b_y", y, 64'd42);
        drain("b2b", 0);

        // Reset in the middle of an operation abandons it.
        start("rstmid", 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid_out_valid", 64'(out_valid), 64'd0);
        chk("rstmid_in_ready", 64'(in_ready), 64'd1);
        chk("rstmid_acc_clear", y, 64'd0);
        bad = 1'b0;
        repeat (20) begin
            tick();
            if (out_valid) bad = 1'b1;
        end
        chk("rstmid_no_result", 64'(bad), 64'd0);
        run_op("rstagain", 32'h1234_5678, 32'h9ABC_DEF0);
        drain("rstagain", 0);

        // Inputs and out_ready are ignored while multiplying.
        ra = $urandom;
        rb = $urandom;
        start("ign", ra, rb);
        cyc = 0;
        bad = 1'b0;
        while (!out_valid && cyc < 100) begin
            in_valid  = 1'b1;
            a         = $urandom;
            b         = $urandom;
            out_ready = 1'($urandom_range(0, 1));
            #1;
            if (in_ready) bad = 1'b1;
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("ign_in_ready_low", 64'(bad), 64'd0);
        chk("ign_lat", 64'(cyc), 64'(LAT));
        chk("ign_y", y, {32'd0, ra} * {32'd0, rb});
        drain("ign", 1);

        for (int n = 0; n < 6; n++) begin
            run_op("rnd", $urandom, $urandom);
            drain("rnd", int'($urandom_range(0, 3)));
        end

        // N=1 instance: single-cycle latency.
        a1        = 16'hFFFF;
        b1        = 16'h0002;
        in_valid1 = 1'b1;
        tick();
        in_valid1 = 1'b0;
        cyc = 0;
        while (!out_valid1 && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("n1_lat", 64'(cyc), 64'd1);
        chk("n1_y", 64'(y1), 64'h0001_FFFE);
        out_ready1 = 1'b1;
        tick();
        out_ready1 = 1'b0;
        chk("n1_drained", 64'(out_valid1), 64'd0);

        for (int n = 0; n < 3; n++) begin
            sa        = 16'($urandom);
            sb        = 16'($urandom);
            a1        = sa;
            b1        = sb;
            in_valid1 = 1'b1;
            tick();
            in_valid1 = 1'b0;
            cyc = 0;
            while (!out_valid1 && cyc < 20) begin
                tick();
                cyc++;
            end
            chk("n1_rnd_lat", 64'(cyc), 64'd1);
            chk("n1_rnd_y", 64'(y1), 64'({16'd0, sa} * {16'd0, sb}));
            out_ready1 = 1'b1;
            tick();
            out_ready1 = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
